// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO with valid/ready handshakes on both sides,
// occupancy level, almost-full/almost-empty flags and a synchronous flush.
module fifo_sync_param #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       data_in_vld,
  output logic                       data_in_rdy,
  output logic [DATA_W-1:0]          data_out,
  output logic                       data_out_vld,
  input  logic                       data_out_rdy,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       almost_full,
  output logic                       almost_empty
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L    = LW'(AF_LEVEL);
  localparam logic [LW-1:0] AE_L    = LW'(AE_LEVEL);
  localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              push;
  logic              pop;

  assign data_in_rdy  = (level < DEPTH_L) & ~rst;
  assign data_out_vld = (level != '0);
  assign data_out     = data_out_vld ? mem[rd_ptr] : '0;
  assign almost_full  = (level >= AF_L);
  assign almost_empty = (level <= AE_L);

  assign push = data_in_vld & data_in_rdy;
  assign pop  = data_out_vld & data_out_rdy;

  // Storage has no reset; a flushed write is dropped since wr_ptr is cleared anyway.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule
